alu_seq64: RTL and testbench

Multi-cycle 64-bit arithmetic/logic sequencer that drives one instance of the existing 32-bit ALU over two consecutive cycles: low word first, then high word with carry chaining. It sits beside the execute stage and serves long-multiply/accumulate and 64-bit compare micro-ops through a valid/ready request/response handshake. It returns a 64-bit result and 64-bit-correct NZCV flags.

---
 rtl/alu_seq64_pkg.sv | 35 +++
 rtl/alu_seq64_if.sv | 22 ++
 rtl/alu_seq64_alu.sv | 37 +++
 rtl/alu_seq64.sv | 80 ++++++++
 tb/tb_alu_seq64.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/alu_seq64_pkg.sv
// alu_seq64_pkg: op, state and 32-bit ALU command encodings plus op-class helpers
package alu_seq64_pkg;
  typedef enum logic [2:0] {
    SEQ_ADD = 3'b000,
    SEQ_ADC = 3'b001,
    SEQ_SUB = 3'b010,
    SEQ_SBC = 3'b011,
    SEQ_AND = 3'b100,
    SEQ_ORR = 3'b101,
    SEQ_EOR = 3'b110,
    SEQ_CMP = 3'b111
  } seq_op_e;
  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_LO   = 2'd1,
    SEQ_HI   = 2'd2,
    SEQ_DONE = 2'd3
  } seq_state_e;
  typedef enum logic [3:0] {
    AND_EXE = 4'h0,
    EOR_EXE = 4'h1,
    SUB_EXE = 4'h2,
    ADD_EXE = 4'h4,
    ADC_EXE = 4'h5,
    SBC_EXE = 4'h6,
    ORR_EXE = 4'hC,
    MOV_EXE = 4'hD
  } alu_cmd_e;
  function automatic logic is_logic(seq_op_e op);
    return op inside {SEQ_AND, SEQ_ORR, SEQ_EOR};
  endfunction
  function automatic logic is_sub(seq_op_e op);
    return op inside {SEQ_SUB, SEQ_SBC, SEQ_CMP};
  endfunction
endpackage

// File: rtl/alu_seq64_if.sv
// alu_seq64_if: request/response bus; master = requester, slave = alu_seq64
interface alu_seq64_if;
  import alu_seq64_pkg::*;
  logic        req_valid;
  logic        req_ready;
  seq_op_e     req_op;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        req_cin;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_result;
  logic [3:0]  rsp_flags;
  modport master (
    output req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags
  );
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_cin, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags
  );
endinterface

// File: rtl/alu_seq64_alu.sv
// alu_seq64_alu: existing 32-bit ALU; ports cmd, val1, val2, cin in; result, sr {z,cout,n,v} out
module alu_seq64_alu
  import alu_seq64_pkg::*;
(
  input  alu_cmd_e    cmd,
  input  logic [31:0] val1,
  input  logic [31:0] val2,
  input  logic        cin,
  output logic [31:0] result,
  output logic [3:0]  sr
);
  logic [32:0] add_sum, sub_sum, sum;
  logic v;
  assign add_sum = {1'b0, val1} + {1'b0, val2} + {32'b0, cin & (cmd == ADC_EXE)};
  assign sub_sum = {1'b0, val1} - {1'b0, val2} - {32'b0, ~cin & (cmd == SBC_EXE)};
  always_comb begin
    sum = 33'd0;
    v = 1'b0;
    case (cmd)
      ADD_EXE, ADC_EXE: begin
        sum = add_sum;
        v = (val1[31] == val2[31]) & (add_sum[31] != val1[31]);
      end
      SUB_EXE, SBC_EXE: begin
        sum = sub_sum;
        v = (val1[31] != val2[31]) & (sub_sum[31] != val1[31]);
      end
      AND_EXE: sum = {1'b0, val1 & val2};
      EOR_EXE: sum = {1'b0, val1 ^ val2};
      ORR_EXE: sum = {1'b0, val1 | val2};
      MOV_EXE: sum = {1'b0, val2};
      default: sum = 33'd0;
    endcase
  end
  assign result = sum[31:0];
  assign sr = {result == 32'd0, sum[32], result[31], v};
endmodule

// File: rtl/alu_seq64.sv
// alu_seq64: 64-bit op over one 32-bit ALU in two cycles; ports clk, rst (async active-low), flush, bus (slave)
module alu_seq64
  import alu_seq64_pkg::*;
(
  input logic         clk,
  input logic         rst,
  input logic         flush,
  alu_seq64_if.slave  bus
);
  seq_state_e  state;
  seq_op_e     op_q;
  logic [63:0] a_q, b_q;
  logic [31:0] lo_q, val1, val2, alu_res;
  logic        cin_q, c_q, lo_zero_q, hi_sel, alu_cin, accept;
  logic [3:0]  sr;
  alu_cmd_e    cmd;
  assign bus.req_ready = ~flush & ((state == SEQ_IDLE) | ((state == SEQ_DONE) & bus.rsp_ready));
  assign accept = bus.req_valid & bus.req_ready;
  always_comb begin
    hi_sel = state == SEQ_HI;
    val1 = hi_sel ? a_q[63:32] : a_q[31:0];
    val2 = (hi_sel ? b_q[63:32] : b_q[31:0]) ^ {32{is_sub(op_q)}};
    alu_cin = hi_sel ? c_q : (op_q == SEQ_ADC || op_q == SEQ_SBC) ? cin_q : is_sub(op_q);
    cmd = op_q == SEQ_AND ? AND_EXE : op_q == SEQ_ORR ? ORR_EXE : op_q == SEQ_EOR ? EOR_EXE : ADC_EXE;
  end
  alu_seq64_alu u_alu (
    .cmd    (cmd),
    .val1   (val1),
    .val2   (val2),
    .cin    (alu_cin),
    .result (alu_res),
    .sr     (sr)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SEQ_IDLE;
      op_q <= SEQ_ADD;
      a_q <= '0;
      b_q <= '0;
      cin_q <= 1'b0;
      c_q <= 1'b0;
      lo_zero_q <= 1'b0;
      lo_q <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_flags <= '0;
    end else if (flush) begin
      state <= SEQ_IDLE;
      bus.rsp_valid <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= bus.req_op;
        a_q <= bus.req_a;
        b_q <= bus.req_b;
        cin_q <= bus.req_cin;
      end
      case (state)
        SEQ_IDLE: state <= accept ? SEQ_LO : SEQ_IDLE;
        SEQ_LO: begin
          lo_q <= alu_res;
          c_q <= sr[2];
          lo_zero_q <= sr[3];
          state <= SEQ_HI;
        end
        SEQ_HI: begin
          if (op_q != SEQ_CMP) bus.rsp_result <= {alu_res, lo_q};
          bus.rsp_flags <= {sr[1], lo_zero_q & sr[3], ~is_logic(op_q) & sr[2], ~is_logic(op_q) & sr[0]};
          bus.rsp_valid <= 1'b1;
          state <= SEQ_DONE;
        end
        SEQ_DONE: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state <= accept ? SEQ_LO : SEQ_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_seq64.sv
// tb_alu_seq64: random + directed check of alu_seq64 against a 64-bit arithmetic model
module tb_alu_seq64;
  import alu_seq64_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  int tests = 0;
  int fails = 0;
  alu_seq64_if bus();
  alu_seq64 dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));
  always #5 clk = ~clk;
  int          m_wait = 0;
  bit          m_valid = 1'b0;
  logic [63:0] m_result = '0;
  logic [3:0]  m_flags = '0;
  logic [63:0] p_res;
  logic [3:0]  p_flags;
  seq_op_e     p_op;
  bit          acc;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic void ref_op(input seq_op_e op, input logic [63:0] a, input logic [63:0] b, input logic c,
                                 output logic [63:0] r, output logic [3:0] f);
    logic [64:0] u;
    logic [65:0] s, sa, sb;
    logic cy, v;
    sa = {{2{a[63]}}, a};
    sb = {{2{b[63]}}, b};
    u = '0;
    s = '0;
    case (op)
      SEQ_ADD: begin u = {1'b0, a} + {1'b0, b}; s = sa + sb; end
      SEQ_ADC: begin u = {1'b0, a} + {1'b0, b} + 65'(c); s = sa + sb + 66'(c); end
      SEQ_SUB, SEQ_CMP: begin u = {1'b0, a} - {1'b0, b}; s = sa - sb; end
      SEQ_SBC: begin u = {1'b0, a} - {1'b0, b} - 65'(!c); s = sa - sb - 66'(!c); end
      SEQ_AND: u = {1'b0, a & b};
      SEQ_ORR: u = {1'b0, a | b};
      default: u = {1'b0, a ^ b};
    endcase
    r = u[63:0];
    cy = (op inside {SEQ_ADD, SEQ_ADC}) ? u[64] : (op inside {SEQ_SUB, SEQ_SBC, SEQ_CMP}) ? !u[64] : 1'b0;
    v = (op inside {SEQ_AND, SEQ_ORR, SEQ_EOR}) ? 1'b0 : (s != {{2{r[63]}}, r});
    f = {r[63], r == 64'd0, cy, v};
  endfunction
  function automatic logic exp_ready();
    return !flush && ((m_wait == 0 && !m_valid) || (m_valid && bus.rsp_ready));
  endfunction
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_wait = 0;
      m_valid = 1'b0;
      m_result = '0;
      m_flags = '0;
    end else if (flush) begin
      m_wait = 0;
      m_valid = 1'b0;
    end else begin
      acc = bus.req_valid && exp_ready();
      if (m_valid && bus.rsp_ready) m_valid = 1'b0;
      if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin
          m_valid = 1'b1;
          if (p_op != SEQ_CMP) m_result = p_res;
          m_flags = p_flags;
        end
      end
      if (acc) begin
        m_wait = 2;
        p_op = bus.req_op;
        ref_op(bus.req_op, bus.req_a, bus.req_b, bus.req_cin, p_res, p_flags);
      end
    end
  end
  always @(posedge clk) begin
    #1;
    if (rst) begin
      chk("req_ready", 64'(bus.req_ready), 64'(exp_ready()));
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_valid));
      chk("rsp_result", bus.rsp_result, m_result);
      chk("rsp_flags", 64'(bus.rsp_flags), 64'(m_flags));
    end
  end
  task automatic drive(input seq_op_e op, input logic [63:0] a, input logic [63:0] b, input logic c);
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_a = a;
    bus.req_b = b;
    bus.req_cin = c;
  endtask
  task automatic run_op(input string nm, input seq_op_e op, input logic [63:0] a, input logic [63:0] b,
                        input logic c, input logic [63:0] er, input logic [3:0] ef);
    logic [63:0] mr;
    logic [3:0] mf;
    int n;
    ref_op(op, a, b, c, mr, mf);
    if (op != SEQ_CMP) chk({nm, " model result"}, mr, er);
    chk({nm, " model flags"}, 64'(mf), 64'(ef));
    drive(op, a, b, c);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'd2);
    chk({nm, " result"}, bus.rsp_result, er);
    chk({nm, " flags"}, 64'(bus.rsp_flags), 64'(ef));
    @(negedge clk);
  endtask
  function automatic logic [63:0] r64();
    case ($urandom_range(0, 6))
      0: return 64'd0;
      1: return {64{1'b1}};
      2: return 64'h7FFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      4: return {32'd0, $urandom()};
      5: return {$urandom(), 32'hFFFF_FFFF};
      default: return {$urandom(), $urandom()};
    endcase
  endfunction
  initial begin
    logic [63:0] held_r;
    logic [3:0] held_f;
    logic [63:0] ra;
    int n;
    bus.req_valid = 1'b0;
    bus.req_op = SEQ_ADD;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_cin = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset rsp_result", bus.rsp_result, 64'd0);
    chk("reset rsp_flags", 64'(bus.rsp_flags), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("ready after reset", 64'(bus.req_ready), 64'd1);
    run_op("add carry", SEQ_ADD, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, 64'h0000_0001_0000_0000, 4'b0000);
    run_op("sub borrow", SEQ_SUB, 64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b1000);
    run_op("add ovf", SEQ_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 4'b1001);
    run_op("cmp eq", SEQ_CMP, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 1'b0, 64'h8000_0000_0000_0000, 4'b0110);
    run_op("eor zero", SEQ_EOR, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 1'b0, 64'd0, 4'b0100);
    run_op("adc wrap", SEQ_ADC, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 4'b0110);
    run_op("sbc noborrow", SEQ_SBC, 64'd5, 64'd3, 1'b1, 64'd2, 4'b0010);
    run_op("sbc borrow", SEQ_SBC, 64'h0000_0001_0000_0000, 64'd0, 1'b0, 64'h0000_0000_FFFF_FFFF, 4'b0010);
    run_op("orr", SEQ_ORR, 64'hF000_0000_0000_0000, 64'h0000_0000_0000_000F, 1'b0, 64'hF000_0000_0000_000F, 4'b1000);
    bus.rsp_ready = 1'b0;
    drive(SEQ_SUB, 64'h0000_0002_0000_0000, 64'd1, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("hold reached done", 64'(bus.rsp_valid), 64'd1);
    held_r = bus.rsp_result;
    held_f = bus.rsp_flags;
    chk("hold result", held_r, 64'h0000_0001_FFFF_FFFF);
    drive(SEQ_AND, r64(), r64(), 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("hold req_ready", 64'(bus.req_ready), 64'd0);
      chk("hold rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("hold stable result", bus.rsp_result, held_r);
      chk("hold stable flags", 64'(bus.rsp_flags), 64'(held_f));
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    drive(SEQ_ADD, 64'd10, 64'd20, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    drive(SEQ_ADD, 64'd1, 64'd1, 1'b0);
    @(negedge clk);
    chk("flush rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("flush keeps result", bus.rsp_result, held_r);
    flush = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    chk("flush idle ready", 64'(bus.req_ready), 64'd1);
    @(negedge clk);
    chk("flush no late rsp", 64'(bus.rsp_valid), 64'd0);
    drive(SEQ_ADD, 64'd1, 64'd2, 1'b0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rst mid rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst mid result", bus.rsp_result, 64'd0);
    chk("rst mid flags", 64'(bus.rsp_flags), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst mid ready", 64'(bus.req_ready), 64'd1);
    for (int i = 0; i < 3000; i++) begin
      ra = r64();
      drive(seq_op_e'($urandom_range(0, 7)), ra, ($urandom_range(0, 3) == 0) ? ra : r64(), 1'($urandom_range(0, 1)));
      bus.req_valid = $urandom_range(0, 99) < 60;
      bus.rsp_ready = $urandom_range(0, 99) < 70;
      flush = $urandom_range(0, 99) < 3;
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    flush = 1'b0;
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
